// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Holds 640x480@60 defaults, coordinate width and the axis state enum.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DIV_DEF      = 4;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_FRONT,
    ST_SYNC,
    ST_BACK
  } axis_st_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping count plus ACTIVE/FRONT/SYNC/BACK state.
// Ports: clk, rst_n, en_i (advance), count_o, state_o, state_nx_o, wrap_o.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en_i,
  output coord_t   count_o,
  output axis_st_e state_o,
  output axis_st_e state_nx_o,
  output logic     wrap_o
);

  localparam int     TOTAL = ACTIVE + FP + SYNC + BP;
  localparam coord_t LAST  = coord_t'(TOTAL - 1);
  localparam coord_t C_FP  = coord_t'(ACTIVE);
  localparam coord_t C_SY  = coord_t'(ACTIVE + FP);
  localparam coord_t C_BP  = coord_t'(ACTIVE + FP + SYNC);

  coord_t   count_q, count_d;
  axis_st_e state_q, state_d;

  assign wrap_o = (count_q == LAST);

  // State follows the next count so it changes on the same edge.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + coord_t'(1);
      unique case (1'b1)
        (count_d == '0):   state_d = ST_ACTIVE;
        (count_d == C_FP): state_d = ST_FRONT;
        (count_d == C_SY): state_d = ST_SYNC;
        (count_d == C_BP): state_d = ST_BACK;
        default:           state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LAST;
      state_q <= ST_BACK;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign count_o    = count_q;
  assign state_o    = state_q;
  assign state_nx_o = state_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel strobe, x/y walk, syncs, video_on, start flags.
// Ports: clk, reset (async low), p_tick, x, y, hsync, vsync, video_on,
// line_start, frame_start, frame_cnt (only with VGA_FRAME_CNT_EN).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV      = DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam int DIV_W = $clog2(DIV);

  logic [DIV_W-1:0] div_q;
  logic             p_tick_q, hsync_q, vsync_q;
  logic             video_on_q, line_q, frame_q;
  logic             adv, div_last;
  logic             h_wrap, v_wrap;
  axis_st_e         h_st, h_nx, v_st, v_nx;
  coord_t           h_cnt, v_cnt;

  // Coordinates step on the edge that raises p_tick, so x/y and the
  // start flags are valid during the p_tick cycle itself.
  assign adv      = (div_q == DIV_W'(DIV - 2));
  assign div_last = (div_q == DIV_W'(DIV - 1));

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .clk        (clk),
    .rst_n      (reset),
    .en_i       (adv),
    .count_o    (h_cnt),
    .state_o    (h_st),
    .state_nx_o (h_nx),
    .wrap_o     (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .clk        (clk),
    .rst_n      (reset),
    .en_i       (adv & h_wrap),
    .count_o    (v_cnt),
    .state_o    (v_st),
    .state_nx_o (v_nx),
    .wrap_o     (v_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      p_tick_q   <= 1'b0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      video_on_q <= 1'b0;
      line_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      div_q      <= div_last ? '0 : div_q + DIV_W'(1);
      p_tick_q   <= adv;
      hsync_q    <= (h_nx == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_q    <= (v_nx == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on_q <= (h_nx == ST_ACTIVE) && (v_nx == ST_ACTIVE);
      line_q     <= adv & h_wrap;
      frame_q    <= adv & h_wrap & v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt_q <= '0;
    end else if (adv & h_wrap & v_wrap) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

  assign p_tick      = p_tick_q;
  assign x           = h_cnt;
  assign y           = v_cnt;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule
